// File: rtl/reg_wr_arbiter.sv
// Shares the single register-file write port between processor writeback
// and the APU, and scoreboards APU destinations for RAW/WAW hazards.
module reg_wr_arbiter #(
    parameter int data_width    = 32,
    parameter int reg_sel_width = 5,
    parameter int num_regs      = 32,
    parameter int starve_limit  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     proc_wr_req,
    input  logic [reg_sel_width-1:0] proc_wr_sel,
    input  logic [data_width-1:0]    proc_wr_data,
    output logic                     proc_wb_stall,
    input  logic                     apu_wr_req,
    input  logic [reg_sel_width-1:0] apu_wr_sel,
    input  logic [data_width-1:0]    apu_wr_data,
    output logic                     apu_ack,
    input  logic                     apu_issue,
    input  logic [reg_sel_width-1:0] apu_issue_sel,
    input  logic [reg_sel_width-1:0] proc_rs1_sel,
    input  logic [reg_sel_width-1:0] proc_rs2_sel,
    input  logic [reg_sel_width-1:0] proc_rd_sel,
    output logic                     hazard,
    output logic [num_regs-1:0]      pending,
    output logic                     rf_wr_req,
    output logic [reg_sel_width-1:0] rf_wr_sel,
    output logic [data_width-1:0]    rf_wr_data
);

    localparam int WCW = $clog2(starve_limit + 1);
    localparam logic [WCW-1:0] LIMIT = WCW'(starve_limit);
    localparam logic [WCW-1:0] ONE   = WCW'(1);

    typedef enum logic {IDLE, ACK} state_t;

    state_t                   state_q, state_d;
    logic [WCW-1:0]           wait_cnt_q, wait_cnt_d;
    logic [num_regs-1:0]      pending_q, pending_d;
    logic                     apu_ack_q, apu_ack_d;
    logic                     rf_wr_req_q, rf_wr_req_d;
    logic [reg_sel_width-1:0] rf_wr_sel_q, rf_wr_sel_d;
    logic [data_width-1:0]    rf_wr_data_q, rf_wr_data_d;

    logic idle, stall, grant_proc, grant_apu;

    always_comb begin
        idle       = (state_q == IDLE);
        stall      = apu_wr_req && (wait_cnt_q >= LIMIT) && idle;
        grant_proc = proc_wr_req && !stall;
        grant_apu  = idle && apu_wr_req && (stall || !proc_wr_req);
    end

    always_comb begin
        state_d      = grant_apu ? ACK : IDLE;
        apu_ack_d    = grant_apu;
        wait_cnt_d   = wait_cnt_q;
        rf_wr_req_d  = 1'b0;
        rf_wr_sel_d  = rf_wr_sel_q;
        rf_wr_data_d = rf_wr_data_q;
        pending_d    = pending_q;

        if (grant_apu) begin
            wait_cnt_d = '0;
        end else if (idle && grant_proc && apu_wr_req && wait_cnt_q < LIMIT) begin
            wait_cnt_d = wait_cnt_q + ONE;
        end

        // Register 0 is hardwired: the write is suppressed but still arbitrated.
        if (grant_proc) begin
            rf_wr_req_d  = (proc_wr_sel != '0);
            rf_wr_sel_d  = proc_wr_sel;
            rf_wr_data_d = proc_wr_data;
        end else if (grant_apu) begin
            rf_wr_req_d  = (apu_wr_sel != '0);
            rf_wr_sel_d  = apu_wr_sel;
            rf_wr_data_d = apu_wr_data;
        end

        // Clear before set so a same-edge issue to the same register wins.
        if (grant_apu) pending_d[apu_wr_sel] = 1'b0;
        if (apu_issue) pending_d[apu_issue_sel] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            pending_q    <= '0;
            apu_ack_q    <= 1'b0;
            rf_wr_req_q  <= 1'b0;
            rf_wr_sel_q  <= '0;
            rf_wr_data_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            pending_q    <= pending_d;
            apu_ack_q    <= apu_ack_d;
            rf_wr_req_q  <= rf_wr_req_d;
            rf_wr_sel_q  <= rf_wr_sel_d;
            rf_wr_data_q <= rf_wr_data_d;
        end
    end

    assign proc_wb_stall = stall;
    assign apu_ack       = apu_ack_q;
    assign pending       = pending_q;
    assign rf_wr_req     = rf_wr_req_q;
    assign rf_wr_sel     = rf_wr_sel_q;
    assign rf_wr_data    = rf_wr_data_q;
    assign hazard        = pending_q[proc_rs1_sel] | pending_q[proc_rs2_sel]
                         | pending_q[proc_rd_sel];

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter: arbitration, starvation guard,
// scoreboard and asynchronous reset.
module tb_reg_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        proc_wr_req;
    logic [4:0]  proc_wr_sel;
    logic [31:0] proc_wr_data;
    logic        proc_wb_stall;
    logic        apu_wr_req;
    logic [4:0]  apu_wr_sel;
    logic [31:0] apu_wr_data;
    logic        apu_ack;
    logic        apu_issue;
    logic [4:0]  apu_issue_sel;
    logic [4:0]  proc_rs1_sel, proc_rs2_sel, proc_rd_sel;
    logic        hazard;
    logic [31:0] pending;
    logic        rf_wr_req;
    logic [4:0]  rf_wr_sel;
    logic [31:0] rf_wr_data;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    reg_wr_arbiter dut (
        .clk(clk), .rst(rst),
        .proc_wr_req(proc_wr_req), .proc_wr_sel(proc_wr_sel),
        .proc_wr_data(proc_wr_data), .proc_wb_stall(proc_wb_stall),
        .apu_wr_req(apu_wr_req), .apu_wr_sel(apu_wr_sel),
        .apu_wr_data(apu_wr_data), .apu_ack(apu_ack),
        .apu_issue(apu_issue), .apu_issue_sel(apu_issue_sel),
        .proc_rs1_sel(proc_rs1_sel), .proc_rs2_sel(proc_rs2_sel),
        .proc_rd_sel(proc_rd_sel), .hazard(hazard), .pending(pending),
        .rf_wr_req(rf_wr_req), .rf_wr_sel(rf_wr_sel),
        .rf_wr_data(rf_wr_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rf_wr_req"}, rf_wr_req, 0);
        chk({tag, ".rf_wr_sel"}, rf_wr_sel, 0);
        chk({tag, ".rf_wr_data"}, rf_wr_data, 0);
        chk({tag, ".apu_ack"}, apu_ack, 0);
        chk({tag, ".pending"}, pending, 0);
        chk({tag, ".stall"}, proc_wb_stall, 0);
        chk({tag, ".hazard"}, hazard, 0);
    endtask

    initial begin
        rst = 1'b0;
        proc_wr_req = 0; proc_wr_sel = 0; proc_wr_data = 0;
        apu_wr_req = 0; apu_wr_sel = 0; apu_wr_data = 0;
        apu_issue = 0; apu_issue_sel = 0;
        proc_rs1_sel = 0; proc_rs2_sel = 0; proc_rd_sel = 0;

        // Reset
        tick(); tick();
        chk_all_zero("rst");
        rst = 1'b1;
        tick();
        chk_all_zero("idle");

        // Lone APU
        apu_issue = 1; apu_issue_sel = 11;
        tick();
        apu_issue = 0; proc_rs1_sel = 11;
        #1;
        chk("lone.pending", pending, 32'h800);
        chk("lone.hazard", hazard, 1);
        apu_wr_req = 1; apu_wr_sel = 11; apu_wr_data = 23;
        tick();
        chk("lone.rf_req", rf_wr_req, 1);
        chk("lone.rf_sel", rf_wr_sel, 11);
        chk("lone.rf_data", rf_wr_data, 23);
        chk("lone.ack", apu_ack, 1);
        chk("lone.pending_clr", pending, 0);
        chk("lone.hazard_clr", hazard, 0);
        apu_wr_req = 0;
        tick();
        chk("lone.ack_drop", apu_ack, 0);
        chk("lone.rf_req_drop", rf_wr_req, 0);
        proc_rs1_sel = 0;

        // Contention: processor first, APU next
        proc_wr_req = 1; proc_wr_sel = 3; proc_wr_data = 5;
        apu_wr_req = 1; apu_wr_sel = 7; apu_wr_data = 321;
        tick();
        chk("cont.p_sel", rf_wr_sel, 3);
        chk("cont.p_data", rf_wr_data, 5);
        chk("cont.p_req", rf_wr_req, 1);
        chk("cont.p_ack", apu_ack, 0);
        proc_wr_req = 0;
        tick();
        chk("cont.a_sel", rf_wr_sel, 7);
        chk("cont.a_data", rf_wr_data, 321);
        chk("cont.a_ack", apu_ack, 1);
        apu_wr_req = 0;
        tick();
        chk("cont.ack_drop", apu_ack, 0);

        // Starvation guard
        proc_wr_req = 1; proc_wr_sel = 4; proc_wr_data = 32'h44;
        apu_wr_req = 1; apu_wr_sel = 7; apu_wr_data = 321;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("starve.nostall%0d", i), proc_wb_stall, 0);
            tick();
            chk($sformatf("starve.psel%0d", i), rf_wr_sel, 4);
            chk($sformatf("starve.noack%0d", i), apu_ack, 0);
        end
        chk("starve.stall", proc_wb_stall, 1);
        tick();
        chk("starve.a_sel", rf_wr_sel, 7);
        chk("starve.a_data", rf_wr_data, 321);
        chk("starve.a_ack", apu_ack, 1);
        chk("starve.unstall", proc_wb_stall, 0);
        apu_wr_req = 0;
        tick();
        chk("starve.resume_sel", rf_wr_sel, 4);
        chk("starve.resume_data", rf_wr_data, 32'h44);
        chk("starve.resume_ack", apu_ack, 0);
        proc_wr_req = 0;
        tick();

        // Same-edge set/clear on register 9
        apu_issue = 1; apu_issue_sel = 9;
        tick();
        apu_wr_req = 1; apu_wr_sel = 9; apu_wr_data = 9;
        tick();
        chk("same.ack", apu_ack, 1);
        chk("same.pending", pending, 32'h200);
        apu_issue = 0; apu_wr_req = 0;
        tick();
        apu_wr_req = 1;
        tick();
        chk("same.cleared", pending, 0);
        apu_wr_req = 0;
        tick();

        // Register 0
        apu_issue = 1; apu_issue_sel = 0;
        apu_wr_req = 1; apu_wr_sel = 0; apu_wr_data = 99;
        tick();
        chk("r0.rf_req", rf_wr_req, 0);
        chk("r0.ack", apu_ack, 1);
        chk("r0.pending", pending, 0);
        apu_issue = 0; apu_wr_req = 0;
        tick();
        proc_wr_req = 1; proc_wr_sel = 0; proc_wr_data = 7;
        tick();
        chk("r0.proc_req", rf_wr_req, 0);
        proc_wr_req = 0;
        tick();

        // Reset during ACK
        apu_issue = 1; apu_issue_sel = 7;
        tick();
        apu_issue_sel = 11;
        tick();
        apu_issue = 0;
        apu_wr_req = 1; apu_wr_sel = 5; apu_wr_data = 1;
        tick();
        chk("mid.ack", apu_ack, 1);
        chk("mid.pending", pending, 32'h880);
        rst = 1'b0;
        #1;
        chk("mid.ack_clr", apu_ack, 0);
        chk("mid.rf_clr", rf_wr_req, 0);
        chk("mid.pend_clr", pending, 0);
        tick();
        rst = 1'b1;
        apu_wr_data = 77;
        tick();
        chk("fresh.ack", apu_ack, 1);
        chk("fresh.sel", rf_wr_sel, 5);
        chk("fresh.data", rf_wr_data, 77);
        apu_wr_req = 0;
        tick();
        chk("fresh.ack_drop", apu_ack, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
